chi_sqr_arbiter: RTL and testbench



---
 rtl/chi_sqr_arbiter_pkg.sv | 27 ++
 rtl/chi_sqr_arbiter_rr_picker.sv | 30 +++
 rtl/chi_sqr_arbiter.sv | 142 ++++++++++++++
 tb/tb_chi_sqr_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chi_sqr_arbiter_pkg.sv
// Shared types and defaults for the chi-square evaluator arbiter.
package chi_sqr_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ACC0  = 3'd2,
    S_ACC1  = 3'd3,
    S_ACC2  = 3'd4,
    S_ACC3  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int IDW      = 3;
  localparam int DEF_W0   = 4767;
  localparam int DEF_W1   = 2788;
  localparam int DEF_W2   = 4442;
  localparam int DEF_W3   = 5461;
  localparam int DEF_U    = 448018;
  localparam int DEF_ACCW = 25;

  function automatic logic [IDW-1:0] next_rr(input logic [IDW-1:0] g, input int n);
    if (int'(g) >= n - 1) return '0;
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/chi_sqr_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit at or above rr, wrapping.
module rr_picker
  import chi_sqr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr,
  output logic [IDW-1:0]   gnt,
  output logic             valid
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  assign dbl = {req, req};
  assign rot = N_REQ'(dbl >> rr);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        gnt   = IDW'((int'(rr) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/chi_sqr_arbiter.sv
// Shared sequential chi-square evaluator with round-robin arbitration.
// Optional debug outputs chi_sqr_o / gnt_id under CHI_SQR_ARBITER_DEBUG_EN.
module chi_sqr_arbiter
  import chi_sqr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int VW    = 5,
  parameter int W0    = DEF_W0,
  parameter int W1    = DEF_W1,
  parameter int W2    = DEF_W2,
  parameter int W3    = DEF_W3,
  parameter int U     = DEF_U,
  parameter int ACCW  = DEF_ACCW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*4*VW-1:0] counts,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      done,
  output logic                  pass,
  output logic                  busy
`ifdef CHI_SQR_ARBITER_DEBUG_EN
  ,
  output logic [ACCW-1:0]       chi_sqr_o,
  output logic [IDW-1:0]        gnt_id
`endif
);

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr, gnt_q, pick;
  logic               pick_vld;
  logic [N_REQ-1:0]   gnt_oh;
  logic [4*VW-1:0]    sel_counts;
  logic [VW-1:0]      v_q [4];
  logic [ACCW-1:0]    acc;
  logic               pass_q;
  logic [VW-1:0]      v_cur;
  logic [12:0]        w_cur;
  logic [2*VW-1:0]    sq;
  logic [2*VW+12:0]   prod;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .rr    (rr),
    .gnt   (pick),
    .valid (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    done      = '0;
    busy      = 1'b0;
    pass      = pass_q;
    case (state)
      S_IDLE:  if (pick_vld) state_nxt = S_GRANT;
      S_GRANT: begin
        busy      = 1'b1;
        ack       = gnt_oh;
        state_nxt = S_ACC0;
      end
      S_ACC0:  begin busy = 1'b1; state_nxt = S_ACC1; end
      S_ACC1:  begin busy = 1'b1; state_nxt = S_ACC2; end
      S_ACC2:  begin busy = 1'b1; state_nxt = S_ACC3; end
      S_ACC3:  begin busy = 1'b1; state_nxt = S_DONE; end
      S_DONE:  begin
        busy      = 1'b1;
        done      = gnt_oh;
        pass      = (acc < ACCW'(U));
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_oh     = '0;
    sel_counts = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q == IDW'(k)) begin
        gnt_oh[k]  = 1'b1;
        sel_counts = counts[k*4*VW +: 4*VW];
      end
    end
  end

  // One squarer and one weight multiplier, time-shared across the four ACC cycles.
  always_comb begin
    v_cur = '0;
    w_cur = '0;
    case (state)
      S_ACC0:  begin v_cur = v_q[0]; w_cur = 13'(W0); end
      S_ACC1:  begin v_cur = v_q[1]; w_cur = 13'(W1); end
      S_ACC2:  begin v_cur = v_q[2]; w_cur = 13'(W2); end
      S_ACC3:  begin v_cur = v_q[3]; w_cur = 13'(W3); end
      default: ;
    endcase
    sq   = {{VW{1'b0}}, v_cur} * {{VW{1'b0}}, v_cur};
    prod = {13'b0, sq} * {{2*VW{1'b0}}, w_cur};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr     <= '0;
      gnt_q  <= '0;
      acc    <= '0;
      pass_q <= 1'b0;
      for (int i = 0; i < 4; i++) v_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (pick_vld) gnt_q <= pick;
        S_GRANT: begin
          for (int i = 0; i < 4; i++) v_q[i] <= sel_counts[i*VW +: VW];
          acc <= '0;
          rr  <= next_rr(gnt_q, N_REQ);
        end
        S_ACC0, S_ACC1, S_ACC2, S_ACC3: acc <= acc + ACCW'(prod);
        S_DONE: pass_q <= pass;
        default: ;
      endcase
    end
  end

`ifdef CHI_SQR_ARBITER_DEBUG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chi_sqr_o <= '0;
      gnt_id    <= '0;
    end else if (state == S_DONE) begin
      chi_sqr_o <= acc;
      gnt_id    <= gnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_chi_sqr_arbiter.sv
// Self-checking bench for chi_sqr_arbiter: service-level schedule model plus directed cases.
module tb_chi_sqr_arbiter;

  localparam int N  = 4;
  localparam int VW = 5;
  localparam int UT = 448018;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*4*VW-1:0] counts;
  logic [N-1:0]     ack, done;
  logic             pass, busy;
`ifdef CHI_SQR_ARBITER_DEBUG_EN
  logic [24:0]      chi_sqr_o;
  logic [2:0]       gnt_id;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_ack3 = 0;

  chi_sqr_arbiter #(.N_REQ(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .counts (counts),
    .ack    (ack),
    .done   (done),
    .pass   (pass),
    .busy   (busy)
`ifdef CHI_SQR_ARBITER_DEBUG_EN
    ,
    .chi_sqr_o (chi_sqr_o),
    .gnt_id    (gnt_id)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] pack(input int v0, input int v1, input int v2, input int v3);
    return {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
  endfunction

  function automatic int chi(input logic [19:0] cv);
    int w [4] = '{4767, 2788, 4442, 5461};
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(cv[i*5 +: 5]) * int'(cv[i*5 +: 5]) * w[i];
    return s;
  endfunction

  // Service-level model: a request seen while the evaluator is free is acked the
  // next cycle, finishes 5 cycles after ack, and the evaluator is free again after that.
  bit         s_active = 0;
  int         s_g = 0, s_ack = 0, s_chi = 0;
  int         m_rr = 0, free_cyc = 0;
  logic       last_pass = 1'b0;
  int         m_dbg_chi = 0, m_dbg_g = 0;
  logic [N-1:0] e_ack, e_done;
  logic       e_busy, e_pass, is_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_active = 0; m_rr = 0; last_pass = 1'b0; free_cyc = cyc + 1;
      m_dbg_chi = 0; m_dbg_g = 0;
    end
    is_done = s_active && (cyc == s_ack + 5);
    e_ack   = (s_active && cyc == s_ack) ? N'(1 << s_g) : '0;
    e_done  = is_done ? N'(1 << s_g) : '0;
    e_busy  = s_active && (cyc >= s_ack) && (cyc <= s_ack + 5);
    e_pass  = is_done ? (s_chi < UT) : last_pass;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("pass", 32'(pass), 32'(e_pass));
`ifdef CHI_SQR_ARBITER_DEBUG_EN
    chk("chi_sqr_o", 32'(chi_sqr_o), 32'(m_dbg_chi));
    chk("gnt_id", 32'(gnt_id), 32'(m_dbg_g));
`endif
    if (ack[3]) n_ack3++;
    if (is_done) begin
      last_pass = e_pass; m_dbg_chi = s_chi; m_dbg_g = s_g; s_active = 0;
    end
    if (rst_n && !s_active && cyc >= free_cyc && req != '0) begin
      for (int i = N - 1; i >= 0; i--)
        if (req[(m_rr + i) % N]) s_g = (m_rr + i) % N;
      s_active = 1;
      s_ack    = cyc + 1;
      s_chi    = chi(counts[s_g*4*VW +: 4*VW]);
      m_rr     = (s_g + 1) % N;
      free_cyc = cyc + 7;
    end
  end

  task automatic wait_ack(input int k, output int c);
    c = -1;
    for (int n = 0; n < 60 && c < 0; n++) begin
      @(negedge clk);
      if (ack[k]) c = cyc;
    end
    chk("ack_timeout", 32'(c >= 0), 32'd1);
  endtask

  task automatic engine(input int k, input int d, input logic [19:0] cv, output int a);
    repeat (d) @(posedge clk);
    #1;
    counts[k*4*VW +: 4*VW] = cv;
    req[k] = 1'b1;
    wait_ack(k, a);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic serve_one(input int k, input logic [19:0] cv, input logic exp_pass);
    int a, d;
    logic p;
    engine(k, 0, cv, a);
    d = -1; p = 1'bx;
    for (int n = 0; n < 20 && d < 0; n++) begin
      @(negedge clk);
      if (done[k]) begin d = cyc; p = pass; end
    end
    chk("done_latency", 32'(d - a), 32'd5);
    chk("pass_literal", 32'(p), 32'(exp_pass));
  endtask

  task automatic wait_idle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, a2, c, base3;
    logic [N-1:0] seq [5];
    int ns;

    rst_n = 1'b0; req = '0; counts = '0;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0); chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0); chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    serve_one(0, pack(4, 6, 4, 2), 1'b1);
    wait_idle();
    serve_one(1, pack(16, 0, 0, 0), 1'b0);
    wait_idle();
    serve_one(2, pack(0, 0, 0, 0), 1'b1);
    wait_idle();
    serve_one(3, pack(1, 0, 0, 9), 1'b1);
    wait_idle();
    serve_one(0, pack(2, 0, 0, 9), 1'b0);
    wait_idle();
    serve_one(1, pack(31, 31, 31, 31), 1'b0);
    wait_idle();

    // All four requesting out of reset, held high.
    rst_n = 1'b0;
    counts = {pack(3, 1, 4, 1), pack(16, 0, 0, 0), pack(1, 0, 0, 9), pack(4, 6, 4, 2)};
    req = 4'hF;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    ns = 0;
    for (int n = 0; n < 80 && ns < 5; n++) begin
      @(negedge clk);
      if (ack != '0) begin seq[ns] = ack; ns++; end
    end
    chk("all4_count", 32'(ns), 5);
    for (int i = 0; i < 5; i++) chk("all4_order", 32'(seq[i]), 32'(1 << (i % 4)));
    @(posedge clk); #1 req = '0;
    wait_idle();

    // rr is 1 here: engine 1 first, then 2 and 0 arrive while busy.
    fork
      engine(1, 0, pack(2, 2, 2, 2), a1);
      engine(2, 3, pack(5, 1, 0, 3), a2);
      engine(0, 3, pack(0, 7, 0, 1), a0);
    join
    chk("rr_1_before_2", 32'(a1 < a2), 1);
    chk("rr_2_before_0", 32'(a2 < a0), 1);
    wait_idle();

    // Short req pulse on engine 3 while busy is never serviced.
    base3 = n_ack3;
    fork
      engine(0, 0, pack(1, 2, 3, 4), a0);
      begin
        repeat (3) @(posedge clk);
        #1 req[3] = 1'b1;
        @(posedge clk); #1 req[3] = 1'b0;
      end
    join
    repeat (15) @(posedge clk);
    chk("pulse_no_ack3", 32'(n_ack3 - base3), 0);
    wait_idle();

    // Reset in ACC2 with engines 1 and 3 pending.
    engine(2, 0, pack(3, 3, 3, 3), a2);
    counts[1*4*VW +: 4*VW] = pack(4, 6, 4, 2);
    counts[3*4*VW +: 4*VW] = pack(0, 0, 1, 1);
    req[1] = 1'b1; req[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ack", 32'(ack), 0); chk("async_done", 32'(done), 0);
    chk("async_busy", 32'(busy), 0); chk("async_pass", 32'(pass), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    c = -1;
    for (int n = 0; n < 20 && c < 0; n++) begin
      @(negedge clk);
      if (ack != '0) begin c = cyc; chk("post_rst_grant", 32'(ack), 32'b0010); end
    end
    chk("post_rst_timeout", 32'(c >= 0), 1);
    @(posedge clk); #1 req[1] = 1'b0;
    wait_ack(3, c);
    @(posedge clk); #1 req[3] = 1'b0;
    wait_idle();

`ifdef CHI_SQR_ARBITER_DEBUG_EN
    serve_one(1, pack(4, 6, 4, 2), 1'b1);
    @(negedge clk);
    chk("dbg_chi", 32'(chi_sqr_o), 32'd269556);
    chk("dbg_gnt", 32'(gnt_id), 32'd1);
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
